// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and defaults for the IF/D memory arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_WAIT = 2'd1,
        D_WAIT  = 2'd2
    } arb_state_e;

    localparam logic GNT_IF = 1'b0;
    localparam logic GNT_D  = 1'b1;

    localparam int DEF_LATENCY = 4;
    localparam int DEF_AW      = 16;
    localparam int DEF_DW      = 16;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester and memory-side signal bundle for mem_arbiter
interface mem_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_ack;
    logic          if_stall;

    logic          d_req;
    logic          d_wr;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_ack;
    logic          d_stall;

    logic          mem_en;
    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_valid;

    logic          busy;
    logic          err;

    modport master (
        input  if_req, if_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata, mem_valid,
        output if_rdata, if_ack, if_stall, d_rdata, d_ack, d_stall,
               mem_en, mem_wr, mem_addr, mem_wdata, busy, err
    );

    modport slave (
        output if_req, if_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata, mem_valid,
        input  if_rdata, if_ack, if_stall, d_rdata, d_ack, d_stall,
               mem_en, mem_wr, mem_addr, mem_wdata, busy, err
    );

endinterface

// File: rtl/mem_latency_timer.sv
// rtl/mem_latency_timer.sv - counts the fixed memory latency and flags mem_valid arriving early
module mem_latency_timer
    import mem_arb_pkg::*;
#(
    parameter int LATENCY = DEF_LATENCY
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic mem_valid,
    output logic done,
    output logic early_valid_err
);
    localparam int CW = $clog2(LATENCY + 1);
    localparam logic [CW-1:0] LAST = CW'(LATENCY - 1);

    logic          run_q, run_d;
    logic [CW-1:0] cnt_q, cnt_d;

    assign done = run_q && (cnt_q == LAST);
    // The launch cycle itself is already inside the wait window, so a response there is early too.
    assign early_valid_err = mem_valid && (start || (run_q && !done));

    always_comb begin
        run_d = run_q;
        cnt_d = cnt_q;
        if (start) begin
            run_d = 1'b1;
            cnt_d = '0;
        end else if (run_q) begin
            if (done) run_d = 1'b0;
            else      cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            run_q <= run_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one fixed-latency memory between the fetch (IF) and data (D) ports
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int LATENCY = DEF_LATENCY,
    parameter int AW      = DEF_AW,
    parameter int DW      = DEF_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.master bus
);
    arb_state_e    state_q, state_d;
    logic          last_grant_q, last_grant_d;
    logic          mem_en_q, mem_en_d;
    logic          mem_wr_q, mem_wr_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          if_ack_q, if_ack_d;
    logic          d_ack_q, d_ack_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic          err_q, err_d;
    logic          if_elig, d_elig;
    logic          timer_done, early_err;

    mem_latency_timer #(.LATENCY(LATENCY)) u_timer (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (mem_en_q),
        .mem_valid       (bus.mem_valid),
        .done            (timer_done),
        .early_valid_err (early_err)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        mem_en_d     = 1'b0;
        mem_wr_d     = mem_wr_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        if_ack_d     = 1'b0;
        d_ack_d      = 1'b0;
        if_rdata_d   = if_rdata_q;
        d_rdata_d    = d_rdata_q;
        err_d        = err_q | early_err | (timer_done & ~bus.mem_valid);
        // A port acked this cycle still holds req; it must not win again.
        if_elig      = bus.if_req & ~if_ack_q;
        d_elig       = bus.d_req & ~d_ack_q;

        unique case (state_q)
            IDLE: begin
                if (d_elig && (!if_elig || last_grant_q == GNT_IF)) begin
                    state_d      = D_WAIT;
                    mem_en_d     = 1'b1;
                    mem_wr_d     = bus.d_wr;
                    mem_addr_d   = bus.d_addr;
                    mem_wdata_d  = bus.d_wdata;
                    last_grant_d = GNT_D;
                end else if (if_elig) begin
                    state_d      = IF_WAIT;
                    mem_en_d     = 1'b1;
                    mem_wr_d     = 1'b0;
                    mem_addr_d   = bus.if_addr;
                    last_grant_d = GNT_IF;
                end
            end
            IF_WAIT: begin
                if (timer_done) begin
                    state_d    = IDLE;
                    if_ack_d   = 1'b1;
                    if_rdata_d = bus.mem_rdata;
                end
            end
            D_WAIT: begin
                if (timer_done) begin
                    state_d = IDLE;
                    d_ack_d = 1'b1;
                    if (!mem_wr_q) d_rdata_d = bus.mem_rdata;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= GNT_IF;
            mem_en_q     <= 1'b0;
            mem_wr_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            if_ack_q     <= 1'b0;
            d_ack_q      <= 1'b0;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            mem_en_q     <= mem_en_d;
            mem_wr_q     <= mem_wr_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            if_ack_q     <= if_ack_d;
            d_ack_q      <= d_ack_d;
            if_rdata_q   <= if_rdata_d;
            d_rdata_q    <= d_rdata_d;
            err_q        <= err_d;
        end
    end

    assign bus.mem_en    = mem_en_q;
    assign bus.mem_wr    = mem_wr_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_ack    = if_ack_q;
    assign bus.d_ack     = d_ack_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.if_stall  = bus.if_req & ~if_ack_q;
    assign bus.d_stall   = bus.d_req & ~d_ack_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.err       = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed and randomized checks of mem_arbiter against a schedule model
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int L = 4;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    int          ref_last;
    bit          ref_err;
    logic [15:0] ref_if_rd;
    logic [15:0] ref_d_rd;

    logic [15:0] mem_arr [logic [15:0]];
    int          resp_cd;
    logic [15:0] resp_data;
    bit          withhold_next;

    mem_arbiter_if #(.AW(16), .DW(16)) bus ();

    mem_arbiter #(.LATENCY(L), .AW(16), .DW(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] mem_read(input logic [15:0] a);
        if (mem_arr.exists(a)) return mem_arr[a];
        return a ^ 16'hC3A5;
    endfunction

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_word(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Memory: answers exactly L cycles after each mem_en, optionally suppressing mem_valid once.
    initial begin
        resp_cd       = 0;
        resp_data     = '0;
        withhold_next = 1'b0;
        bus.mem_valid = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            bus.mem_valid = 1'b0;
            if (resp_cd > 0) begin
                resp_cd--;
                if (resp_cd == 0) begin
                    bus.mem_rdata = resp_data;
                    if (withhold_next) withhold_next = 1'b0;
                    else bus.mem_valid = 1'b1;
                end
            end
            if (bus.mem_en === 1'b1) begin
                resp_cd = L;
                if (bus.mem_wr === 1'b1) mem_arr[bus.mem_addr] = bus.mem_wdata;
                resp_data = mem_read(bus.mem_addr);
            end
        end
    end

    // One request set from IDLE; port 0 = IF, port 1 = D.
    task automatic txn(input bit ireq, input bit dreq, input bit dwr, input logic [15:0] ia,
                       input logic [15:0] da, input logic [15:0] dwd, input bit hold_resp);
        int          en_k  [2];
        int          ack_k [2];
        int          first;
        int          last_k;
        bit          drop_if;
        bit          drop_d;
        bit          exp_busy;
        logic [15:0] exp_if_rd;
        logic [15:0] exp_d_rd;
        en_k    = '{0, 0};
        ack_k   = '{0, 0};
        drop_if = 1'b0;
        drop_d  = 1'b0;
        if (ireq && dreq) first = (ref_last == int'(GNT_D)) ? 0 : 1;
        else              first = dreq ? 1 : 0;
        en_k[first]  = 1;
        ack_k[first] = L + 2;
        ref_last     = first;
        if (ireq && dreq) begin
            en_k[1-first]  = L + 3;
            ack_k[1-first] = 2 * L + 4;
            ref_last       = 1 - first;
        end
        exp_if_rd = mem_read(ia);
        exp_d_rd  = dwr ? ref_d_rd : mem_read(da);
        if (hold_resp) begin
            withhold_next = 1'b1;
            ref_err       = 1'b1;
        end
        last_k = ((ack_k[0] > ack_k[1]) ? ack_k[0] : ack_k[1]) + 2;

        @(negedge clk);
        bus.if_req  = ireq;
        bus.if_addr = ia;
        bus.d_req   = dreq;
        bus.d_wr    = dwr;
        bus.d_addr  = da;
        bus.d_wdata = dwd;

        for (int k = 1; k <= last_k; k++) begin
            @(posedge clk);
            #1;
            if (drop_if) bus.if_req = 1'b0;
            if (drop_d)  bus.d_req  = 1'b0;
            @(negedge clk);
            chk_bit("mem_en", bus.mem_en, (k == en_k[0]) || (k == en_k[1]));
            if (k == en_k[0]) begin
                chk_word("mem_addr_if", bus.mem_addr, ia);
                chk_bit("mem_wr_if", bus.mem_wr, 1'b0);
            end else if (k == en_k[1]) begin
                chk_word("mem_addr_d", bus.mem_addr, da);
                chk_bit("mem_wr_d", bus.mem_wr, dwr);
                if (dwr) chk_word("mem_wdata", bus.mem_wdata, dwd);
            end
            chk_bit("if_ack", bus.if_ack, k == ack_k[0]);
            chk_bit("d_ack", bus.d_ack, k == ack_k[1]);
            if (k == ack_k[0]) begin
                chk_word("if_rdata", bus.if_rdata, exp_if_rd);
                ref_if_rd = exp_if_rd;
                drop_if   = 1'b1;
            end
            if (k == ack_k[1]) begin
                chk_word("d_rdata", bus.d_rdata, exp_d_rd);
                ref_d_rd = exp_d_rd;
                drop_d   = 1'b1;
            end
            chk_bit("if_stall", bus.if_stall, bus.if_req && (k != ack_k[0]));
            chk_bit("d_stall", bus.d_stall, bus.d_req && (k != ack_k[1]));
            exp_busy = (en_k[0] != 0 && k >= en_k[0] && k < ack_k[0]) ||
                       (en_k[1] != 0 && k >= en_k[1] && k < ack_k[1]);
            chk_bit("busy", bus.busy, exp_busy);
        end
        chk_bit("err_after_txn", bus.err, ref_err);
        chk_word("if_rdata_held", bus.if_rdata, ref_if_rd);
        chk_word("d_rdata_held", bus.d_rdata, ref_d_rd);
    endtask

    task automatic chk_all_zero(input string tag);
        chk_bit({tag, "_if_ack"}, bus.if_ack, 1'b0);
        chk_bit({tag, "_d_ack"}, bus.d_ack, 1'b0);
        chk_bit({tag, "_if_stall"}, bus.if_stall, 1'b0);
        chk_bit({tag, "_d_stall"}, bus.d_stall, 1'b0);
        chk_bit({tag, "_mem_en"}, bus.mem_en, 1'b0);
        chk_bit({tag, "_mem_wr"}, bus.mem_wr, 1'b0);
        chk_bit({tag, "_busy"}, bus.busy, 1'b0);
        chk_bit({tag, "_err"}, bus.err, 1'b0);
        chk_word({tag, "_mem_addr"}, bus.mem_addr, 16'h0000);
        chk_word({tag, "_mem_wdata"}, bus.mem_wdata, 16'h0000);
        chk_word({tag, "_if_rdata"}, bus.if_rdata, 16'h0000);
        chk_word({tag, "_d_rdata"}, bus.d_rdata, 16'h0000);
    endtask

    bit          r_ir, r_dr, r_w;
    logic [15:0] r_ia, r_da, r_dd;

    initial begin
        errors      = 0;
        checks      = 0;
        ref_last    = int'(GNT_IF);
        ref_err     = 1'b0;
        ref_if_rd   = '0;
        ref_d_rd    = '0;
        rst_n       = 1'b0;
        bus.if_req  = 1'b0;
        bus.if_addr = '0;
        bus.d_req   = 1'b0;
        bus.d_wr    = 1'b0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;

        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        mem_arr[16'h0010] = 16'hA123;
        txn(1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'h0000, 1'b0);

        txn(1'b1, 1'b1, 1'b0, 16'h0020, 16'h0200, 16'h0000, 1'b0);
        txn(1'b1, 1'b1, 1'b0, 16'h0024, 16'h0204, 16'h0000, 1'b0);

        txn(1'b0, 1'b1, 1'b1, 16'h0000, 16'h0300, 16'hBEEF, 1'b0);

        txn(1'b1, 1'b0, 1'b0, 16'h0040, 16'h0000, 16'h0000, 1'b1);
        txn(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0300, 16'h0000, 1'b0);

        // Abort a D read mid-wait; its response later arrives while IDLE.
        @(negedge clk);
        bus.d_req  = 1'b1;
        bus.d_wr   = 1'b0;
        bus.d_addr = 16'h0500;
        repeat (3) @(negedge clk);
        chk_bit("busy_before_reset", bus.busy, 1'b1);
        rst_n     = 1'b0;
        bus.d_req = 1'b0;
        #1;
        chk_all_zero("midop_reset");
        ref_last  = int'(GNT_IF);
        ref_err   = 1'b0;
        ref_if_rd = '0;
        ref_d_rd  = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 2 * L + 4; k++) begin
            @(negedge clk);
            chk_bit("post_reset_d_ack", bus.d_ack, 1'b0);
            chk_bit("post_reset_mem_en", bus.mem_en, 1'b0);
            chk_bit("post_reset_err", bus.err, 1'b0);
            chk_bit("post_reset_busy", bus.busy, 1'b0);
        end

        for (int i = 0; i < 24; i++) begin
            r_ir = 1'($urandom_range(0, 1));
            r_dr = 1'($urandom_range(0, 1));
            if (!r_ir && !r_dr) r_ir = 1'b1;
            r_w  = 1'($urandom_range(0, 1));
            r_ia = 16'($urandom_range(0, 16'h0FFF));
            r_da = 16'h4000 | 16'($urandom_range(0, 15));
            r_dd = 16'($urandom);
            txn(r_ir, r_dr, r_w, r_ia, r_da, r_dd, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-ported, fixed-latency unified memory between the fetch stage (IF port, read-only) and the memory stage (D port, read/write).
- Grants one request at a time and launches it to memory.
- Returns data and a one-cycle ack to the winning requester, and drives per-port stall so the pipeline holds while waiting.

Parameters:
LATENCY, 4, cycles from the mem_en cycle to the cycle in which mem_valid/mem_rdata are presented; legal range >= 1
AW, 16, address width
DW, 16, data width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
if_req  in  1  fetch read request; level, held until if_ack
if_addr  in  AW  fetch address; stable while if_req is high
if_rdata  out  DW  fetched instruction; valid while if_ack is high, held afterwards
if_ack  out  1  one-cycle completion pulse for IF
if_stall  out  1  if_req & ~if_ack
d_req  in  1  data request; level, held until d_ack
d_wr  in  1  1 = write, 0 = read; stable while d_req is high
d_addr  in  AW  data address
d_wdata  in  DW  write data
d_rdata  out  DW  read data; valid while d_ack is high, held afterwards
d_ack  out  1  one-cycle completion pulse for D
d_stall  out  1  d_req & ~d_ack
mem_en  out  1  one-cycle launch strobe
mem_wr  out  1  write qualifier for mem_en
mem_addr  out  AW  latched address
mem_wdata  out  DW  latched write data
mem_rdata  in  DW  memory read data
mem_valid  in  1  memory completion strobe
busy  out  1  1 when the state is not IDLE
err  out  1  sticky protocol error

Behaviour:
- States: IDLE, IF_WAIT, D_WAIT. All registers are cleared asynchronously when rst_n = 0.
- Reset values: state = IDLE; every output = 0; last_grant = IF.
- Arbitration (IDLE only):
  - Only one requester pending: that requester is granted.
  - Both pending: D wins, unless last_grant = D, in which case IF wins (alternation, so there is no starvation).
  - A port whose ack is high in the current cycle is excluded from arbitration that cycle, because its req is still held.
- Grant edge:
  - state moves to IF_WAIT or D_WAIT.
  - mem_en = 1 for exactly one cycle; mem_wr = d_wr for a D grant, 0 for an IF grant.
  - mem_addr and mem_wdata are latched from the winner and held until the next grant.
  - cnt is cleared; last_grant is updated.
- WAIT:
  - cnt increments each cycle.
  - Expected completion cycle is the LATENCY-th cycle after the mem_en cycle (cnt == LATENCY-1).
  - At that cycle's edge: state returns to IDLE; the granted port's ack = 1 for one cycle.
  - For a read, the granted port's rdata is loaded from mem_rdata. For a D write, d_rdata is unchanged.
- Latency: request seen in cycle N -> mem_en in N+1 -> mem_valid in N+1+LATENCY -> ack in N+2+LATENCY. With both requests pending, the second launch comes 1 cycle after the first ack cycle.
- Back-to-back from one port: a new req asserted in the cycle after its ack is eligible in that cycle.
- err is set (sticky until reset) when either of these holds:
  - mem_valid = 0 at the expected completion cycle;
  - mem_valid = 1 in a WAIT state before the expected cycle.
  - Completion still proceeds on schedule when err is set.
  - mem_valid while IDLE is ignored. This covers stale responses after a mid-operation reset.
- Reset mid-operation: returns to IDLE immediately. No ack is issued for the aborted request, and requesters must re-request.
- Req dropped before ack: not permitted; the transaction still completes and its ack is issued.
- Widths: cnt is clog2(LATENCY+1) bits and does not wrap within a transaction.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum (IDLE, IF_WAIT, D_WAIT);
  - grant encoding constants GNT_IF = 0, GNT_D = 1;
  - default LATENCY/AW/DW constants.
- One natural sub-module: mem_latency_timer, with inputs start and LATENCY and outputs done and early_valid_err. It owns cnt and the valid-timing checks.

Test Plan:
- Single IF read, LATENCY = 4, if_addr = 0x0010, memory returns 0xA123 at the expected cycle:
  - mem_en appears 1 cycle after the req, with mem_addr = 0x0010 and mem_wr = 0;
  - if_ack appears 6 cycles after req is seen, with if_rdata = 0xA123;
  - if_stall is high for cycles 0-5.
- Simultaneous if_req and d_req (read 0x0200) from reset:
  - D is granted first, then IF launches 1 cycle after the d_ack cycle;
  - repeating with both held, grants alternate D, IF, D, IF.
- D write, d_addr = 0x0300, d_wdata = 0xBEEF:
  - mem_en = 1 with mem_wr = 1 and mem_wdata = 0xBEEF;
  - d_ack appears after LATENCY+1 cycles;
  - d_rdata is unchanged from its prior value.
- Requester holds req through its ack cycle and drops it afterwards -> no duplicate grant, and mem_en pulses exactly once.
- Memory model withholds mem_valid at the expected cycle -> err = 1 and stays 1; ack is still issued on schedule.
- rst_n pulsed low in D_WAIT, then a stale mem_valid arrives while IDLE:
  - the state is IDLE and all outputs are 0 immediately;
  - no d_ack is issued and err stays 0.
